instr_sequencer: RTL
====================

// Module: instr_sequencer
// PURPOSE
//  Fetch/issue sequencer sitting in front of control_unit. Walks a program ROM
//  with a program counter, splits each 8-bit word into opcode[7:4]/imm[3:0],
//  issues ALU/register opcodes to control_unit and resolves flow-control
//  opcodes (JMP, JZ, NOP, HALT) locally. Gated by the external button ex_btn.
// PARAMETERS
//  AW      8   program-ROM address width; PC range 0..2**AW-1
//  DW      8   instruction width; opcode = [DW-1:DW-4], imm = [3:0]
// PORTS
//  clk        in   1   system clock, rising edge
//  rstn       in   1   asynchronous, active-low reset
//  ex_btn     in   1   external button, asynchronous; 2-FF synchronised inside
//  zero_flag  in   1   ALU zero flag, sampled in EXEC for JZ
//  mem_rd_en  out  1   ROM read strobe (synchronous ROM, 1-cycle read latency)
//  mem_addr   out  AW  ROM address (= pc while fetching)
//  mem_rdata  in   DW  ROM data, valid the cycle after mem_rd_en
//  opcode     out  4   opcode to control_unit; held stable between issues
//  imm        out  4   immediate field of current instruction
//  op_valid   out  1   1-cycle pulse: opcode is a datapath op (0000..1011)
//  pc         out  AW  current program counter
//  busy       out  1   high in FETCH/DECODE/EXEC
//  halted     out  1   high in HALT
// BEHAVIOUR
//  Reset: state=IDLE, pc=0, opcode=0000, imm=0, op_valid=0, mem_rd_en=0,
//   mem_addr=0, busy=0, halted=0, sync flops=0. Reset mid-instruction aborts
//   it immediately; no partial op_valid is ever produced.
//  btn_s = ex_btn after 2-FF synchroniser (2-cycle latency); btn_rise = edge.
//  FSM: IDLE -> FETCH -> DECODE -> EXEC -> (FETCH | IDLE | HALT); HALT sticky.
//   IDLE  : go when start condition true (see CONFIGURATION) -> FETCH.
//   FETCH : mem_rd_en=1, mem_addr=pc, 1 cycle -> DECODE.
//   DECODE: latch opcode<=mem_rdata[7:4], imm<=mem_rdata[3:0] -> EXEC.
//   EXEC  : one cycle; action by opcode:
//     0000..1011 op_valid=1 this cycle; pc<=pc+1
//     1100 JMP   pc<={AW-4 zeros,imm}
//     1101 JZ    zero_flag ? pc<={0,imm} : pc<=pc+1
//     1110 NOP   pc<=pc+1
//     1111 HALT  pc unchanged -> HALT (exit only by rstn)
//    then -> FETCH if continue condition true, else IDLE.
//  Throughput: 3 clk per instruction; op_valid never in consecutive cycles.
//  pc+1 wraps 2**AW-1 -> 0 silently. JMP to own address loops forever (legal).
//  opcode/imm hold last decoded value in IDLE/HALT; control_unit acts only on
//   op_valid.
//  ex_btn changes mid-instruction never abort it; sampled only in IDLE/EXEC.
// CONFIGURATION
//  SINGLE_STEP_EN defined: start = btn_rise in IDLE; continue = 0, so exactly
//   one instruction per button press, then IDLE. Held button = one step.
//  SINGLE_STEP_EN undefined (run mode): start = btn_s in IDLE; continue = btn_s
//   in EXEC; releasing the button finishes current instruction, then IDLE.
// TESTING
//  1 Reset: rstn=0 for 35ns, ex_btn=0 -> all outputs at reset values, state IDLE
//    for 20 cycles.
//  2 Run mode, ROM[0..3]=8'h01,8'h22,8'h3F,8'hF0, ex_btn=1 -> op_valid pulses with
//    opcode 0000,0010,0011 at 3-cycle spacing, then halted=1, pc=3, stays halted.
//  3 JZ: ROM[0]=8'hD5, zero_flag=1 -> pc=5 after EXEC; rerun with zero_flag=0
//    -> pc=1; op_valid never asserted.
//  4 Wrap: AW=4, ROM all 8'hE0 (NOP), run 17 instructions -> pc sequence 0..15,0,1.
//  5 SINGLE_STEP_EN: ROM[0..2]=8'h10,8'h20,8'h30; three button pulses -> exactly
//    three op_valid pulses (0001,0010,0011), pc=3, IDLE; held button = one step.
//  6 Reset mid-op: assert rstn=0 during DECODE of 8'h41 -> no op_valid, pc=0,
//    restart re-executes from address 0.

Source files
------------

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/issue sequencer in front of control_unit.
// Walks a synchronous program ROM with a PC. It splits each word into
// opcode[DW-1:DW-4] and imm[3:0]. Datapath opcodes (0000..1011) go to
// control_unit as a one-cycle op_valid pulse. JMP, JZ, NOP and HALT are
// resolved locally. Each instruction takes FETCH, DECODE and EXEC (3 clocks).
// Optional feature macro: SINGLE_STEP_EN
//   defined   : one instruction per rising edge of the synchronised button.
//   undefined : run mode. The sequencer runs while the synchronised button is
//               high, and finishes the current instruction when it is released.
// Handshake: op_valid is a single-cycle strobe with no ready/back-pressure.
// opcode/imm are valid in the cycle op_valid is high, and are held until the
// next DECODE.
module instr_sequencer #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          ex_btn,
  input  logic          zero_flag,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic [3:0]    opcode,
  output logic [3:0]    imm,
  output logic          op_valid,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          halted,
  output logic [2:0]    dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_JZ   = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t        r_state;
  logic [AW-1:0] r_pc;
  logic [AW-1:0] r_mem_addr;
  logic [3:0]    r_opcode;
  logic [3:0]    r_imm;
  logic          r_op_valid;
  logic          r_mem_rd_en;
  logic          r_busy;
  logic          r_halted;
  logic          r_sync1;
  logic          r_sync2;
  logic          r_sync3;

  logic          w_btn_s;
  logic          w_btn_rise;
  logic          w_start;
  logic          w_cont;
  logic [3:0]    w_rd_op;
  logic [3:0]    w_rd_imm;
  logic [AW-1:0] w_pc_inc;
  logic [AW-1:0] w_imm_pc;
  logic [AW-1:0] w_next_pc;

  assign w_btn_s    = r_sync2;
  assign w_btn_rise = r_sync2 & ~r_sync3;

`ifdef SINGLE_STEP_EN
  assign w_start = w_btn_rise;
  assign w_cont  = 1'b0;
`else
  assign w_start = w_btn_s;
  assign w_cont  = w_btn_s;
`endif

  assign w_rd_op  = mem_rdata[DW-1:DW-4];
  assign w_rd_imm = mem_rdata[3:0];
  assign w_pc_inc = r_pc + AW'(1);
  assign w_imm_pc = AW'(r_imm);

  // Next PC for the instruction sitting in EXEC. The increment wraps silently.
  always_comb begin
    w_next_pc = w_pc_inc;
    case (r_opcode)
      OP_JMP:  w_next_pc = w_imm_pc;
      OP_JZ:   w_next_pc = zero_flag ? w_imm_pc : w_pc_inc;
      OP_HALT: w_next_pc = r_pc;
      default: w_next_pc = w_pc_inc;
    endcase
  end

  // Two-flop synchroniser for the asynchronous button, plus a delay flop for edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= ex_btn;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  // Sequencer FSM. All outputs are registered and set on the edge that enters each state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_pc        <= '0;
      r_mem_addr  <= '0;
      r_opcode    <= 4'h0;
      r_imm       <= 4'h0;
      r_op_valid  <= 1'b0;
      r_mem_rd_en <= 1'b0;
      r_busy      <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      r_op_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state     <= S_FETCH;
            r_mem_rd_en <= 1'b1;
            r_mem_addr  <= r_pc;
            r_busy      <= 1'b1;
          end
        end
        S_FETCH: begin
          r_mem_rd_en <= 1'b0;
          r_state     <= S_DECODE;
        end
        S_DECODE: begin
          r_opcode   <= w_rd_op;
          r_imm      <= w_rd_imm;
          r_op_valid <= (w_rd_op < OP_JMP);
          r_state    <= S_EXEC;
        end
        S_EXEC: begin
          if (r_opcode == OP_HALT) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
            r_busy   <= 1'b0;
          end else begin
            r_pc <= w_next_pc;
            if (w_cont) begin
              r_state     <= S_FETCH;
              r_mem_rd_en <= 1'b1;
              r_mem_addr  <= w_next_pc;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state     <= S_IDLE;
          r_mem_rd_en <= 1'b0;
          r_busy      <= 1'b0;
          r_halted    <= 1'b0;
        end
      endcase
    end
  end

  assign mem_rd_en = r_mem_rd_en;
  assign mem_addr  = r_mem_addr;
  assign opcode    = r_opcode;
  assign imm       = r_imm;
  assign op_valid  = r_op_valid;
  assign pc        = r_pc;
  assign busy      = r_busy;
  assign halted    = r_halted;
  assign dbg_state = r_state;

endmodule
